pkt_in_arbiter: RTL and testbench
=================================

# pkt_in_arbiter

Packet-granular round-robin arbiter that merges two 512-bit AXI-Stream packet sources (e.g. the host DMA path and the physical port path) onto the single slave input of the packet filter. Whole packets are never interleaved: once a source is granted, it owns the output until its `tlast` beat is accepted. The output is a single registered stage, so the filter input sees clean, registered `tvalid`/`tdata` independent of source timing.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 512, tdata width of all ports.
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width of all ports.
- `clk`  in  1  single clock for all logic.
- `areset`  in  1  asynchronous, active-high reset.
- `s0_axis_tdata/tkeep/tuser/tvalid/tlast`  in  512/64/128/1/1  source 0 stream.
- `s0_axis_tready`  out  1  source 0 ready.
- `s1_axis_tdata/tkeep/tuser/tvalid/tlast`  in  512/64/128/1/1  source 1 stream.
- `s1_axis_tready`  out  1  source 1 ready.
- `m_axis_tdata/tkeep/tuser/tvalid/tlast`  out  512/64/128/1/1  merged stream to the filter.
- `m_axis_tready`  in  1  filter ready.
- `pkt_cnt0`, `pkt_cnt1`  out  32  packets forwarded from each source.

## Operation
- States: `IDLE`, `SEND0`, `SEND1`. Reset state: `IDLE`. Priority pointer `prio` resets to 0, meaning source 0 wins a tie.
- IDLE:
  - Neither `sN_axis_tvalid` high: stay in IDLE.
  - Exactly one high: go to `SENDn` for that source.
  - Both high: go to `SEND<prio>`.
  - No beat is accepted in IDLE. Both `tready` outputs are 0.
- SENDn:
  - `sn_axis_tready = !m_axis_tvalid || m_axis_tready`. The other source's `tready` is 0.
  - An accepted beat (`sn_tvalid && sn_tready`) loads the output register with data, keep, user and last, and sets `m_axis_tvalid`=1.
  - When the accepted beat has `tlast`=1: go to IDLE, set `prio` to the other source, and increment `pkt_cntn`.
- Output register:
  - Cleared (`m_axis_tvalid`=0) when `m_axis_tready`=1 and no new beat is loaded that cycle.
  - Holds its value while `m_axis_tvalid && !m_axis_tready`.
- `tdata`, `tkeep`, `tuser` and `tlast` are forwarded unmodified. Single-beat packets (`tlast` on the first beat) are legal.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Both sources are assumed AXI-compliant: once `tvalid` is asserted, it is held until accepted. The arbiter does not re-arbitrate when a granted source deasserts `tvalid` mid-packet. It stays in `SENDn` and waits.

## Timing
- Reset values: all `m_axis_*` = 0, both `tready` = 0, `pkt_cnt0`/`pkt_cnt1` = 0, state IDLE, `prio` = 0.
- Arbitration costs exactly one IDLE cycle per packet. The first beat of a packet is accepted no earlier than the cycle after `tvalid` is first seen in IDLE.
- Input-to-output latency: 1 cycle. A beat accepted at edge k is on `m_axis_*` after edge k.
- Throughput inside a packet is 1 beat/cycle when `m_axis_tready` is held at 1. Back-to-back packets therefore cost N+1 cycles each.
- Back-pressure: when `m_axis_tready`=0 with the output register full, the granted `tready` drops in the same cycle, combinationally. No beat is dropped or duplicated.
- `areset` asserted mid-packet:
  - Everything returns to reset values immediately (asynchronously). Any partially forwarded packet is truncated.
  - The downstream filter sees `m_axis_tvalid` fall without a `tlast`.
  - Upstream sources must be reset on the same reset.

## Structure
- Shared package holds:
  - the `IDLE`/`SEND0`/`SEND1` state encoding (2-bit localparams);
  - the AXIS width defaults (512/64/128).
- One sub-module: `axis_reg_slice`. It is the single-stage output register with `ready = !valid || m_ready`, and can be reused in front of other RMT stages.
- The arbiter FSM, `prio`, the input mux and the counters live in the top module.

## Test plan
- Single source: s0 sends a 4-beat packet (tdata top bytes ff/ef/df/cf, `tlast` on beat 4), `m_axis_tready`=1.
  - Expect 4 identical beats on `m_axis` starting 2 cycles after `s0_tvalid` rises.
  - Expect `pkt_cnt0`=1 and `s1_tready` held at 0 throughout.
- Tie after reset: s0 and s1 both assert `tvalid` in the same cycle with 2-beat packets.
  - Expect the s0 packet in full, one IDLE bubble, then the s1 packet.
  - Expect `pkt_cnt0`=1, `pkt_cnt1`=1.
- Fairness: s0 and s1 both continuously offer 1-beat packets for 10 packets.
  - Expect strict alternation s0, s1, s0, … and final counts 5/5.
- Back-pressure: hold `m_axis_tready`=0 for 3 cycles in the middle of a 4-beat packet.
  - Expect the output beat held stable and the granted `tready`=0 during the stall.
  - Expect no loss or duplication, and the `tlast` beat to arrive exactly once.
- Grant stickiness: s0 packet in flight with a 2-cycle `tvalid` gap; s1 asserts `tvalid` during the gap.
  - Expect s1 `tready` to stay 0 until the s0 `tlast` is accepted, then the s1 packet after one IDLE cycle.
- Reset mid-packet: assert `areset` on beat 2 of 4.
  - Expect `m_axis_tvalid`, both `tready` outputs and both counters at 0 before the next clock edge.
  - Expect a new s1 packet after reset to be forwarded normally.

Source files
------------

// File: rtl/pkt_in_arbiter_pkg.sv
// pkt_in_arbiter_pkg
//   Shared definitions for the packet input arbiter and its output stage:
//   AXI-Stream width defaults and the arbiter state encoding.
package pkt_in_arbiter_pkg;

    localparam int unsigned AXIS_DATA_W = 512;
    localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int unsigned AXIS_USER_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice
//   Single-stage registered AXI-Stream slice. Upstream ready is
//   !valid || downstream ready, so a full register stalls the source in the
//   same cycle the sink stalls, and one beat per cycle flows when the sink
//   is always ready.
// Ports:
//   i_clk, i_areset          clock, asynchronous active-high reset
//   i_s_* / o_s_ready        upstream beat (data/keep/user/last/valid), ready
//   o_m_* / i_m_ready        registered downstream beat, sink ready
module axis_reg_slice #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 128
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [DATA_W-1:0]     i_s_data,
    input  logic [DATA_W/8-1:0]   i_s_keep,
    input  logic [USER_W-1:0]     i_s_user,
    input  logic                  i_s_last,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic [DATA_W-1:0]     o_m_data,
    output logic [DATA_W/8-1:0]   o_m_keep,
    output logic [USER_W-1:0]     o_m_user,
    output logic                  o_m_last,
    output logic                  o_m_valid,
    input  logic                  i_m_ready
);

    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_keep;
    logic [USER_W-1:0]   r_user;
    logic                r_last;
    logic                r_valid;
    logic                w_ready;
    logic                w_load;

    assign w_ready   = !r_valid || i_m_ready;
    assign w_load    = i_s_valid && w_ready;
    assign o_s_ready = w_ready;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= i_s_data;
            r_keep  <= i_s_keep;
            r_user  <= i_s_user;
            r_last  <= i_s_last;
            r_valid <= 1'b1;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_data  = r_data;
    assign o_m_keep  = r_keep;
    assign o_m_user  = r_user;
    assign o_m_last  = r_last;
    assign o_m_valid = r_valid;

endmodule

// File: rtl/pkt_in_arbiter.sv
// pkt_in_arbiter
//   Packet-granular round-robin merge of two AXI-Stream sources onto one
//   registered output. A granted source owns the output until its tlast beat
//   is accepted; the loser of a tie wins the next tie.
// Ports:
//   clk, areset                        clock, asynchronous active-high reset
//   s0_axis_* / s0_axis_tready         source 0 stream
//   s1_axis_* / s1_axis_tready         source 1 stream
//   m_axis_* / m_axis_tready           merged registered stream
//   pkt_cnt0, pkt_cnt1                 packets forwarded per source (wrap)
module pkt_in_arbiter
    import pkt_in_arbiter_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = AXIS_USER_W
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s0_axis_tuser,
    input  logic                               s0_axis_tvalid,
    input  logic                               s0_axis_tlast,
    output logic                               s0_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s1_axis_tuser,
    input  logic                               s1_axis_tvalid,
    input  logic                               s1_axis_tlast,
    output logic                               s1_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [31:0]                        pkt_cnt0,
    output logic [31:0]                        pkt_cnt1
);

    arb_state_t  r_state;
    logic        r_prio;
    logic [31:0] r_pkt_cnt0;
    logic [31:0] r_pkt_cnt1;

    logic                              w_slice_ready;
    logic                              w_accept;
    logic                              w_sel_valid;
    logic                              w_sel_last;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    w_sel_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  w_sel_keep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_sel_user;

    // Input mux: only the granted source can present a beat; IDLE offers none.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = s0_axis_tlast;
        w_sel_data  = s0_axis_tdata;
        w_sel_keep  = s0_axis_tkeep;
        w_sel_user  = s0_axis_tuser;
        case (r_state)
            SEND0: w_sel_valid = s0_axis_tvalid;
            SEND1: begin
                w_sel_valid = s1_axis_tvalid;
                w_sel_last  = s1_axis_tlast;
                w_sel_data  = s1_axis_tdata;
                w_sel_keep  = s1_axis_tkeep;
                w_sel_user  = s1_axis_tuser;
            end
            default: ;
        endcase
    end

    assign w_accept       = w_sel_valid && w_slice_ready;
    assign s0_axis_tready = (r_state == SEND0) && w_slice_ready;
    assign s1_axis_tready = (r_state == SEND1) && w_slice_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s0_axis_tvalid && s1_axis_tvalid)
                        r_state <= r_prio ? SEND1 : SEND0;
                    else if (s0_axis_tvalid)
                        r_state <= SEND0;
                    else if (s1_axis_tvalid)
                        r_state <= SEND1;
                end
                SEND0: begin
                    if (w_accept && s0_axis_tlast) begin
                        r_state    <= IDLE;
                        r_prio     <= 1'b1;
                        r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
                    end
                end
                SEND1: begin
                    if (w_accept && s1_axis_tlast) begin
                        r_state    <= IDLE;
                        r_prio     <= 1'b0;
                        r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;

    axis_reg_slice #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_out_slice (
        .i_clk     (clk),
        .i_areset  (areset),
        .i_s_data  (w_sel_data),
        .i_s_keep  (w_sel_keep),
        .i_s_user  (w_sel_user),
        .i_s_last  (w_sel_last),
        .i_s_valid (w_sel_valid),
        .o_s_ready (w_slice_ready),
        .o_m_data  (m_axis_tdata),
        .o_m_keep  (m_axis_tkeep),
        .o_m_user  (m_axis_tuser),
        .o_m_last  (m_axis_tlast),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_pkt_in_arbiter.sv
// tb_pkt_in_arbiter
//   Directed bench for pkt_in_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are checked in the same window, clear of the edge.
module tb_pkt_in_arbiter;

    logic         clk = 1'b0;
    logic         areset;
    logic [511:0] s0_axis_tdata,  s1_axis_tdata;
    logic [63:0]  s0_axis_tkeep,  s1_axis_tkeep;
    logic [127:0] s0_axis_tuser,  s1_axis_tuser;
    logic         s0_axis_tvalid, s1_axis_tvalid;
    logic         s0_axis_tlast,  s1_axis_tlast;
    logic         s0_axis_tready, s1_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]  pkt_cnt0, pkt_cnt1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pkt_in_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (512),
        .C_S_AXIS_TUSER_WIDTH (128)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mkd(input logic [7:0] top, input logic [7:0] lo);
        return {top, 496'd0, lo};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [511:0] d, input logic l);
        s0_axis_tvalid = v;
        s0_axis_tdata  = d;
        s0_axis_tlast  = l;
    endtask

    task automatic drv1(input logic v, input logic [511:0] d, input logic l);
        s1_axis_tvalid = v;
        s1_axis_tdata  = d;
        s1_axis_tlast  = l;
    endtask

    task automatic reset_dut();
        areset = 1'b1;
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
        m_axis_tready = 1'b1;
        cyc();
        cyc();
        areset = 1'b0;
    endtask

    // Hard stop if anything stalls beyond all reasonable cycle budgets.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d0 [4];
        logic       hs0, hs1;
        int         k, ncyc, s0_seq, s1_seq;

        d0[0] = 8'hff; d0[1] = 8'hef; d0[2] = 8'hdf; d0[3] = 8'hcf;
        s0_axis_tkeep = '1;
        s1_axis_tkeep = 64'h0000_0000_ffff_ffff;
        s0_axis_tuser = 128'h5a;
        s1_axis_tuser = 128'ha5;

        // ---------------- reset state ----------------
        reset_dut();
        areset = 1'b1;
        cyc();
        chk("rst_mvalid", 512'(m_axis_tvalid), 512'd0);
        chk("rst_mdata",  m_axis_tdata, 512'd0);
        chk("rst_mkeep",  512'(m_axis_tkeep), 512'd0);
        chk("rst_muser",  512'(m_axis_tuser), 512'd0);
        chk("rst_mlast",  512'(m_axis_tlast), 512'd0);
        chk("rst_rdy",    512'({s0_axis_tready, s1_axis_tready}), 512'd0);
        chk("rst_cnt",    512'({pkt_cnt0, pkt_cnt1}), 512'd0);
        areset = 1'b0;
        cyc();

        // ---------------- single source, 4-beat packet ----------------
        drv0(1'b1, mkd(d0[0], 8'd0), 1'b0);
        chk("t1_idle_rdy0", 512'(s0_axis_tready), 512'd0);
        cyc();
        chk("t1_grant_rdy0", 512'(s0_axis_tready), 512'd1);
        chk("t1_no_out_yet", 512'(m_axis_tvalid), 512'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_mvalid", 512'(m_axis_tvalid), 512'd1);
            chk("t1_mdata",  m_axis_tdata, mkd(d0[i], 8'(i)));
            chk("t1_mlast",  512'(m_axis_tlast), 512'(i == 3));
            chk("t1_mkeep",  512'(m_axis_tkeep), 512'(64'hffff_ffff_ffff_ffff));
            chk("t1_rdy1",   512'(s1_axis_tready), 512'd0);
            if (i < 3) drv0(1'b1, mkd(d0[i+1], 8'(i + 1)), (i == 2));
            else       drv0(1'b0, '0, 1'b0);
        end
        chk("t1_cnt0", 512'(pkt_cnt0), 512'd1);
        cyc();
        chk("t1_drain", 512'(m_axis_tvalid), 512'd0);

        // ---------------- tie after reset ----------------
        reset_dut();
        drv0(1'b1, mkd(8'h10, 8'd0), 1'b0);
        drv1(1'b1, mkd(8'h20, 8'd0), 1'b0);
        cyc();
        cyc();
        chk("t2_a0", m_axis_tdata, mkd(8'h10, 8'd0));
        chk("t2_a0_rdy1", 512'(s1_axis_tready), 512'd0);
        drv0(1'b1, mkd(8'h10, 8'd1), 1'b1);
        cyc();
        chk("t2_a1", m_axis_tdata, mkd(8'h10, 8'd1));
        chk("t2_a1_last", 512'(m_axis_tlast), 512'd1);
        chk("t2_bubble_rdy", 512'({s0_axis_tready, s1_axis_tready}), 512'd0);
        drv0(1'b0, '0, 1'b0);
        cyc();
        chk("t2_bubble_mvalid", 512'(m_axis_tvalid), 512'd0);
        chk("t2_grant1", 512'(s1_axis_tready), 512'd1);
        cyc();
        chk("t2_b0", m_axis_tdata, mkd(8'h20, 8'd0));
        chk("t2_b0_keep", 512'(m_axis_tkeep), 512'(64'h0000_0000_ffff_ffff));
        chk("t2_b0_user", 512'(m_axis_tuser), 512'(128'ha5));
        drv1(1'b1, mkd(8'h20, 8'd1), 1'b1);
        cyc();
        chk("t2_b1", m_axis_tdata, mkd(8'h20, 8'd1));
        chk("t2_b1_last", 512'(m_axis_tlast), 512'd1);
        drv1(1'b0, '0, 1'b0);
        chk("t2_cnt", 512'({pkt_cnt0, pkt_cnt1}), 512'({32'd1, 32'd1}));

        // ---------------- fairness: 10 single-beat packets ----------------
        reset_dut();
        s0_seq = 0; s1_seq = 0; k = 0; ncyc = 0;
        drv0(1'b1, mkd(8'ha0, 8'd0), 1'b1);
        drv1(1'b1, mkd(8'hb0, 8'd0), 1'b1);
        while (k < 10 && ncyc < 60) begin
            hs0 = s0_axis_tvalid && s0_axis_tready;
            hs1 = s1_axis_tvalid && s1_axis_tready;
            cyc();
            ncyc++;
            if (hs0) begin
                s0_seq++;
                if (s0_seq == 5) drv0(1'b0, '0, 1'b0);
                else             drv0(1'b1, mkd(8'ha0, 8'(s0_seq)), 1'b1);
            end
            if (hs1) begin
                s1_seq++;
                if (s1_seq == 5) drv1(1'b0, '0, 1'b0);
                else             drv1(1'b1, mkd(8'hb0, 8'(s1_seq)), 1'b1);
            end
            if (m_axis_tvalid) begin
                chk("t3_order", m_axis_tdata,
                    (k % 2 == 0) ? mkd(8'ha0, 8'(k / 2)) : mkd(8'hb0, 8'(k / 2)));
                k++;
            end
        end
        chk("t3_pkts", 512'(k), 512'd10);
        chk("t3_cycles", 512'(ncyc), 512'd20);
        chk("t3_cnt0", 512'(pkt_cnt0), 512'd5);
        chk("t3_cnt1", 512'(pkt_cnt1), 512'd5);
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);

        // ---------------- back-pressure mid-packet ----------------
        reset_dut();
        drv0(1'b1, mkd(8'hc0, 8'd0), 1'b0);
        cyc();
        cyc();
        chk("t4_c0", m_axis_tdata, mkd(8'hc0, 8'd0));
        drv0(1'b1, mkd(8'hc0, 8'd1), 1'b0);
        cyc();
        chk("t4_c1", m_axis_tdata, mkd(8'hc0, 8'd1));
        drv0(1'b1, mkd(8'hc0, 8'd2), 1'b0);
        m_axis_tready = 1'b0;
        #1;
        chk("t4_rdy_drop", 512'(s0_axis_tready), 512'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_hold_data",  m_axis_tdata, mkd(8'hc0, 8'd1));
            chk("t4_hold_valid", 512'(m_axis_tvalid), 512'd1);
            chk("t4_hold_rdy",   512'(s0_axis_tready), 512'd0);
        end
        m_axis_tready = 1'b1;
        #1;
        chk("t4_rdy_back", 512'(s0_axis_tready), 512'd1);
        cyc();
        chk("t4_c2", m_axis_tdata, mkd(8'hc0, 8'd2));
        chk("t4_c2_last", 512'(m_axis_tlast), 512'd0);
        drv0(1'b1, mkd(8'hc0, 8'd3), 1'b1);
        cyc();
        chk("t4_c3", m_axis_tdata, mkd(8'hc0, 8'd3));
        chk("t4_c3_last", 512'(m_axis_tlast), 512'd1);
        chk("t4_cnt0", 512'(pkt_cnt0), 512'd1);
        drv0(1'b0, '0, 1'b0);
        cyc();
        chk("t4_no_dup", 512'(m_axis_tvalid), 512'd0);

        // ---------------- grant stickiness across a tvalid gap ----------------
        reset_dut();
        drv0(1'b1, mkd(8'he0, 8'd0), 1'b0);
        cyc();
        cyc();
        chk("t5_e0", m_axis_tdata, mkd(8'he0, 8'd0));
        drv0(1'b0, '0, 1'b0);
        drv1(1'b1, mkd(8'hf0, 8'd0), 1'b1);
        chk("t5_gap_rdy1_a", 512'(s1_axis_tready), 512'd0);
        cyc();
        chk("t5_gap_rdy1_b", 512'(s1_axis_tready), 512'd0);
        chk("t5_gap_mvalid", 512'(m_axis_tvalid), 512'd0);
        cyc();
        chk("t5_gap_rdy1_c", 512'(s1_axis_tready), 512'd0);
        drv0(1'b1, mkd(8'he0, 8'd1), 1'b1);
        cyc();
        chk("t5_e1", m_axis_tdata, mkd(8'he0, 8'd1));
        chk("t5_e1_rdy1", 512'(s1_axis_tready), 512'd0);
        chk("t5_cnt0", 512'(pkt_cnt0), 512'd1);
        drv0(1'b0, '0, 1'b0);
        cyc();
        chk("t5_grant1", 512'(s1_axis_tready), 512'd1);
        cyc();
        chk("t5_f0", m_axis_tdata, mkd(8'hf0, 8'd0));
        chk("t5_f0_last", 512'(m_axis_tlast), 512'd1);
        chk("t5_cnt1", 512'(pkt_cnt1), 512'd1);
        drv1(1'b0, '0, 1'b0);
        cyc();

        // ---------------- asynchronous reset mid-packet ----------------
        drv0(1'b1, mkd(8'h70, 8'd0), 1'b0);
        cyc();
        cyc();
        drv0(1'b1, mkd(8'h70, 8'd1), 1'b0);
        cyc();
        chk("t6_g1", m_axis_tdata, mkd(8'h70, 8'd1));
        drv0(1'b1, mkd(8'h70, 8'd2), 1'b0);
        #2;
        areset = 1'b1;
        #1;
        chk("t6_async_mvalid", 512'(m_axis_tvalid), 512'd0);
        chk("t6_async_rdy", 512'({s0_axis_tready, s1_axis_tready}), 512'd0);
        chk("t6_async_cnt", 512'({pkt_cnt0, pkt_cnt1}), 512'd0);
        drv0(1'b0, '0, 1'b0);
        cyc();
        areset = 1'b0;
        drv1(1'b1, mkd(8'h80, 8'd0), 1'b0);
        cyc();
        chk("t6_grant1", 512'(s1_axis_tready), 512'd1);
        cyc();
        chk("t6_h0", m_axis_tdata, mkd(8'h80, 8'd0));
        drv1(1'b1, mkd(8'h80, 8'd1), 1'b1);
        cyc();
        chk("t6_h1", m_axis_tdata, mkd(8'h80, 8'd1));
        chk("t6_h1_last", 512'(m_axis_tlast), 512'd1);
        chk("t6_cnt", 512'({pkt_cnt0, pkt_cnt1}), 512'({32'd0, 32'd1}));
        drv1(1'b0, '0, 1'b0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
